multi_sel_sched: RTL and testbench
==================================

Name: multi_sel_sched

Overview:
- Round-robin scheduler that shares one 4-phase shift-add multiply datapath among NREQ requesters.
- Grants one requester at a time and captures its operand.
- Sequences four result phases: d*1, d*3, d*7, d*8. Each result is tagged with the requester id and phase.
- Sits between the operand producers and the result consumer, replacing the free-running 2-bit phase counter with request-driven sequencing.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 8, operand width
IDW, 2, requester id width, must be >= clog2(NREQ)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
req  input  NREQ  request per requester; held with data until granted
data_i  input  NREQ*DW  operands; requester i on data_i[i*DW +: DW]
grant  output  NREQ  one-hot, one-cycle pulse; operand of that requester captured
busy  output  1  high while a sequence is in progress
out_valid  output  1  result valid this cycle
out_data  output  DW+3  result
out_id  output  IDW  requester id of result
out_phase  output  2  0:d*1, 1:d*3, 2:d*7, 3:d*8

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- All outputs are registered.
- Reset values: grant=0, busy=0, out_valid=0, out_data=0, out_id=0, out_phase=0. State=IDLE, d_reg=0, rr_ptr=NREQ-1, so requester 0 has first priority.
- FSM states:
  - IDLE: if req!=0 at an edge, issue a grant.
  - RUN: phases 0..3 follow.
- Grant edge E0:
  - Winner is the first set req bit searching rr_ptr+1, rr_ptr+2, ... with wrap-around modulo NREQ.
  - grant<=onehot(winner), d_reg<=data_i[winner], id_reg<=winner, rr_ptr<=winner.
  - busy<=1, state<=RUN, phase<=0.
- grant clears at the next edge unless a new grant is issued there.
- Result edges E1..E4: out_valid<=1, out_id<=id_reg, out_phase<=k.
  - E1: d_reg
  - E2: (d_reg<<1)+d_reg
  - E3: (d_reg<<2)+(d_reg<<1)+d_reg
  - E4: d_reg<<3
- All arithmetic is zero-extended to DW+3 bits, so there is no overflow (255*7=1785, 255*8=2040).
- At E4: state<=IDLE and busy<=0. At E5: out_valid<=0 unless another sequence is already producing a result; out_data holds its last value.
- Latency: grant to first result is 1 cycle; grant to last result is 4 cycles. Default grant-to-grant period is 5 cycles.
- req is sampled only in IDLE (or at E4 with the feature enabled). Requests withdrawn before a grant are ignored; nothing is latched.
- A requester still asserting req after its grant is treated as a new request and re-enters round-robin. Requesters must drop req in the cycle grant is seen.
- No requests in IDLE: stay in IDLE with all outputs idle.
- rst asserted mid-sequence: abort immediately to reset values. No further out_valid for the aborted operand. rr_ptr returns to NREQ-1.
- data_i changes after the grant do not affect the running sequence; d_reg is frozen for the whole sequence.

Optional Feature:
- Macro: MULTI_SEL_SCHED_B2B_EN.
- Defined:
  - Arbitration also runs at E4. If req!=0, grant/d_reg/id_reg/rr_ptr update at E4.
  - The phase-3 result at E4 still uses the old d_reg and old id.
  - state stays RUN, busy stays 1, and the next phase 0 appears at E5.
  - Grant-to-grant period is 4 cycles; out_valid is continuously high under sustained load.
- Undefined: arbitration happens only in IDLE, giving a 5-cycle period with one idle cycle of out_valid=0 between sequences.

Test Plan:
- Sequence values: reset, then req=4'b0001, data_i[0]=8'd5 → grant=0001 for one cycle. Next 4 cycles give out_data 5, 15, 35, 40 with out_phase 0..3 and out_id=0. busy is high from E0 through E4.
- Max operand: req=4'b0100, data=8'd255 → out_data 255, 765, 1785, 2040 with out_id=2, no truncation.
- Round-robin: all four req held high (re-asserted after each grant), operands 1/2/3/4 → grant order 0,1,2,3,0. Each sequence's results carry the matching out_id.
- Pointer wrap: after granting 2, req=4'b1001 → 3 is granted first, then 0.
- Reset mid-run: assert rst after the E2 result (d=9) → outputs clear asynchronously with no E3/E4 results. After release, req=4'b0010 → requester 1 is granted (priority from 0, requester 0 idle).
- Throughput: two requesters continuously requesting. Without the macro, the grant period is 5 cycles with one out_valid=0 gap. With MULTI_SEL_SCHED_B2B_EN, the period is 4 cycles with no gap; E4 outputs the old d*8 while grant shows the new winner.

Source files
------------

// File: rtl/multi_sel_sched.sv
`default_nettype none
// ============================================================================
// Module      : multi_sel_sched
// Description : Round-robin scheduler sharing one 4-phase shift-add multiply
//               datapath (d*1, d*3, d*7, d*8) among NREQ requesters.
//               Optional macro MULTI_SEL_SCHED_B2B_EN enables back-to-back
//               arbitration on the last result phase.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_sel_sched #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   data_i,
    output logic [NREQ-1:0]      grant,
    output logic                 busy,
    output logic                 out_valid,
    output logic [DW+2:0]        out_data,
    output logic [IDW-1:0]       out_id,
    output logic [1:0]           out_phase
);

    localparam int OW = DW + 3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          phase_q, phase_d;
    logic [DW-1:0]       d_q, d_d;
    logic [IDW-1:0]      id_q, id_d;
    logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0]     grant_q, grant_d;
    logic                busy_q, busy_d;
    logic                out_valid_q, out_valid_d;
    logic [OW-1:0]       out_data_q, out_data_d;
    logic [IDW-1:0]      out_id_q, out_id_d;
    logic [1:0]          out_phase_q, out_phase_d;

    logic                win_found;
    logic [IDW-1:0]      win_idx;
    logic [NREQ-1:0]     win_onehot;
    logic [DW-1:0]       win_data;
    logic [NREQ-1:0]     req_sh;
    int                  cand;
    logic                take;
    logic [OW-1:0]       d_ext;
    logic [OW-1:0]       res;

    // Scan from the farthest candidate back to rr_ptr+1 so the nearest
    // requesting index is the last one written and therefore wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        req_sh    = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand   = (int'(rr_ptr_q) + k) % NREQ;
            req_sh = req >> cand;
            if (req_sh[0]) begin
                win_found = 1'b1;
                win_idx   = IDW'(cand);
            end
        end
    end

    always_comb begin
        win_onehot = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
        win_data   = DW'(data_i >> (int'(win_idx) * DW));
    end

    // Shift-add products, zero-extended so d*8 of a full-scale operand fits.
    always_comb begin
        d_ext = {3'b000, d_q};
        res   = d_ext;
        case (phase_q)
            2'd0:    res = d_ext;
            2'd1:    res = (d_ext << 1) + d_ext;
            2'd2:    res = (d_ext << 2) + (d_ext << 1) + d_ext;
            2'd3:    res = d_ext << 3;
            default: res = d_ext;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        d_d         = d_q;
        id_d        = id_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = '0;
        busy_d      = busy_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        out_phase_d = out_phase_q;
        take        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (win_found) begin
                    take = 1'b1;
                end
            end
            ST_RUN: begin
                out_valid_d = 1'b1;
                out_data_d  = res;
                out_id_d    = id_q;
                out_phase_d = phase_q;
                phase_d     = phase_q + 2'd1;
                if (phase_q == 2'd3) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
`ifdef MULTI_SEL_SCHED_B2B_EN
                    // Last product above still uses the old operand/id.
                    if (win_found) begin
                        take = 1'b1;
                    end
`else
                    take = 1'b0;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (take) begin
            grant_d  = win_onehot;
            d_d      = win_data;
            id_d     = win_idx;
            rr_ptr_d = win_idx;
            busy_d   = 1'b1;
            state_d  = ST_RUN;
            phase_d  = 2'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            phase_q     <= 2'd0;
            d_q         <= '0;
            id_q        <= '0;
            rr_ptr_q    <= IDW'(NREQ - 1);
            grant_q     <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            out_phase_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            d_q         <= d_d;
            id_q        <= id_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            out_phase_q <= out_phase_d;
        end
    end

    assign grant     = grant_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign out_phase = out_phase_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_sel_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_sel_sched
// Description : Directed self-checking bench for multi_sel_sched; honours
//               MULTI_SEL_SCHED_B2B_EN for the throughput expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_sel_sched;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [NREQ*DW-1:0]  data_i;
    logic [NREQ-1:0]     grant;
    logic                busy;
    logic                out_valid;
    logic [DW+2:0]       out_data;
    logic [IDW-1:0]      out_id;
    logic [1:0]          out_phase;

    int n_tests = 0;
    int n_fail  = 0;

    int tp_g  [11];
    int tp_v  [11];
    int tp_id [11];
    int tp_ph [11];
    int tp_d  [11];

    multi_sel_sched #(
        .NREQ (NREQ),
        .DW   (DW),
        .IDW  (IDW)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data_i    (data_i),
        .grant     (grant),
        .busy      (busy),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_phase (out_phase)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_data(input int idx, input int val);
        data_i[idx*DW +: DW] = DW'(val);
    endtask

    // Entered at a falling edge with the DUT idle; leaves at the falling edge after E4.
    task automatic run_seq(input string tag, input logic [NREQ-1:0] req_v, input int win,
                           input int e0, input int e1, input int e2, input int e3);
        int exp_r [4];
        exp_r = '{e0, e1, e2, e3};
        req = req_v;
        @(negedge clk);
        check_val({tag, " grant"},     32'(grant),     32'(1 << win));
        check_val({tag, " busy0"},     32'(busy),      32'(1));
        check_val({tag, " valid0"},    32'(out_valid), 32'(0));
        req = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_val({tag, " valid"}, 32'(out_valid), 32'(1));
            check_val({tag, " data"},  32'(out_data),  32'(exp_r[k]));
            check_val({tag, " id"},    32'(out_id),    32'(win));
            check_val({tag, " phase"}, 32'(out_phase), 32'(k));
            check_val({tag, " gclr"},  32'(grant),     32'(0));
            check_val({tag, " busy"},  32'(busy),      32'((k < 3) ? 1 : 0));
        end
    endtask

    initial begin
        rst    = 1'b1;
        req    = '0;
        data_i = '0;
        repeat (2) @(negedge clk);
        check_val("rst grant",  32'(grant),     32'(0));
        check_val("rst busy",   32'(busy),      32'(0));
        check_val("rst valid",  32'(out_valid), 32'(0));
        check_val("rst data",   32'(out_data),  32'(0));
        check_val("rst id",     32'(out_id),    32'(0));
        check_val("rst phase",  32'(out_phase), 32'(0));
        rst = 1'b0;

        @(negedge clk);
        check_val("idle grant", 32'(grant),     32'(0));
        check_val("idle busy",  32'(busy),      32'(0));
        check_val("idle valid", 32'(out_valid), 32'(0));

        set_data(0, 5);
        run_seq("seq5", 4'b0001, 0, 5, 15, 35, 40);
        @(negedge clk);
        check_val("seq5 e5 valid", 32'(out_valid), 32'(0));
        check_val("seq5 e5 hold",  32'(out_data),  32'(40));
        check_val("seq5 e5 busy",  32'(busy),      32'(0));

        set_data(2, 255);
        run_seq("max", 4'b0100, 2, 255, 765, 1785, 2040);

        set_data(3, 4);
        set_data(0, 1);
        run_seq("wrap3", 4'b1001, 3, 4, 12, 28, 32);
        run_seq("wrap0", 4'b1001, 0, 1, 3, 7, 8);

        // Abort mid-sequence; operand is also changed after grant to prove it is frozen.
        set_data(3, 9);
        req = 4'b1000;
        @(negedge clk);
        check_val("abort grant", 32'(grant), 32'(8));
        req = '0;
        set_data(3, 200);
        @(negedge clk);
        check_val("abort e1", 32'(out_data), 32'(9));
        @(negedge clk);
        check_val("abort e2", 32'(out_data), 32'(27));
        #2 rst = 1'b1;
        #1;
        check_val("abort valid", 32'(out_valid), 32'(0));
        check_val("abort busy",  32'(busy),      32'(0));
        check_val("abort data",  32'(out_data),  32'(0));
        check_val("abort id",    32'(out_id),    32'(0));
        check_val("abort phase", 32'(out_phase), 32'(0));
        @(negedge clk);
        check_val("abort hold1", 32'(out_valid), 32'(0));
        rst = 1'b0;
        @(negedge clk);
        check_val("abort hold2", 32'(out_valid), 32'(0));

        set_data(1, 6);
        run_seq("post_rst", 4'b0010, 1, 6, 18, 42, 48);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_data(0, 1);
        set_data(1, 2);
        set_data(2, 3);
        set_data(3, 4);
        run_seq("rr0", 4'b1111, 0, 1, 3, 7, 8);
        run_seq("rr1", 4'b1111, 1, 2, 6, 14, 16);
        run_seq("rr2", 4'b1111, 2, 3, 9, 21, 24);
        run_seq("rr3", 4'b1111, 3, 4, 12, 28, 32);
        run_seq("rr4", 4'b1111, 0, 1, 3, 7, 8);

        // Two requesters held continuously; pointer sits at 0 so 1 wins first.
        set_data(0, 10);
        set_data(1, 20);
`ifdef MULTI_SEL_SCHED_B2B_EN
        tp_g  = '{2, 0, 0, 0, 1, 0, 0, 0, 2, 0, 0};
        tp_v  = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        tp_id = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1};
        tp_ph = '{0, 0, 1, 2, 3, 0, 1, 2, 3, 0, 1};
        tp_d  = '{0, 20, 60, 140, 160, 10, 30, 70, 80, 20, 60};
`else
        tp_g  = '{2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2};
        tp_v  = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        tp_id = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
        tp_ph = '{0, 0, 1, 2, 3, 0, 0, 1, 2, 3, 0};
        tp_d  = '{0, 20, 60, 140, 160, 0, 10, 30, 70, 80, 0};
`endif
        req = 4'b0011;
        for (int s = 0; s < 11; s++) begin
            @(negedge clk);
            check_val($sformatf("tput%0d grant", s), 32'(grant),     32'(tp_g[s]));
            check_val($sformatf("tput%0d valid", s), 32'(out_valid), 32'(tp_v[s]));
            if (tp_v[s] != 0) begin
                check_val($sformatf("tput%0d id", s),    32'(out_id),    32'(tp_id[s]));
                check_val($sformatf("tput%0d phase", s), 32'(out_phase), 32'(tp_ph[s]));
                check_val($sformatf("tput%0d data", s),  32'(out_data),  32'(tp_d[s]));
            end
        end
        req = '0;
        repeat (7) @(negedge clk);
        check_val("drain busy",  32'(busy),      32'(0));
        check_val("drain valid", 32'(out_valid), 32'(0));
        check_val("drain grant", 32'(grant),     32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
